// File: rtl/ieee754_argmax_stream_pkg.sv
// Shared definitions for the IEEE-754 comparator and the streaming extremum unit:
// FSM encoding, min/max mode codes and width-generic field classification helpers.
package fp_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    // Helpers take fields zero-extended to these widths plus the live exponent width.
    localparam int FP_EXP_MAX = 16;
    localparam int FP_MAN_MAX = 64;

    function automatic logic is_nan(input logic [FP_EXP_MAX-1:0] exp_f,
                                    input logic [FP_MAN_MAX-1:0] man_f,
                                    input int                    exp_w);
        logic [FP_EXP_MAX-1:0] ones;
        ones = {FP_EXP_MAX{1'b1}} >> (FP_EXP_MAX - exp_w);
        return (exp_f == ones) && (man_f != {FP_MAN_MAX{1'b0}});
    endfunction

    function automatic logic is_zero(input logic [FP_EXP_MAX-1:0] exp_f,
                                     input logic [FP_MAN_MAX-1:0] man_f);
        return (exp_f == {FP_EXP_MAX{1'b0}}) && (man_f == {FP_MAN_MAX{1'b0}});
    endfunction

endpackage

// File: rtl/ieee754_argmax_stream_if.sv
// Element stream in, frame result out. The master side produces elements and
// consumes results; the slave side is the extremum unit.
interface ieee754_argmax_stream_if #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int MAX_LEN = 16
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic             mode;
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [W-1:0]     out_value;
    logic [IDX_W-1:0] out_index;
    logic             out_all_nan;
    logic             out_overflow;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output mode, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_value, out_index, out_all_nan, out_overflow, out_valid
    );

    modport slave (
        input  mode, in_data, in_valid, in_last, out_ready,
        output in_ready, out_value, out_index, out_all_nan, out_overflow, out_valid
    );
endinterface

// File: rtl/ieee754_argmax_stream_cmp_core.sv
// Combinational IEEE-754 two-operand comparator for generic exponent/mantissa widths.
// Signed zeros compare equal, denormals order by magnitude, NaN makes the pair unordered.
module ieee754_cmp_core
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] i_a,
    input  logic [EXP_W+MAN_W:0] i_b,
    output logic                 a_gt_b,
    output logic                 a_eq_b,
    output logic                 unordered
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             w_a_sign;
    logic             w_b_sign;
    logic [W-2:0]     w_a_mag;
    logic [W-2:0]     w_b_mag;
    logic             w_a_nan;
    logic             w_b_nan;
    logic             w_a_zero;
    logic             w_b_zero;

    assign w_a_sign = i_a[W-1];
    assign w_b_sign = i_b[W-1];
    assign w_a_mag  = i_a[W-2:0];
    assign w_b_mag  = i_b[W-2:0];

    assign w_a_nan  = is_nan(FP_EXP_MAX'(i_a[W-2 -: EXP_W]), FP_MAN_MAX'(i_a[MAN_W-1:0]), EXP_W);
    assign w_b_nan  = is_nan(FP_EXP_MAX'(i_b[W-2 -: EXP_W]), FP_MAN_MAX'(i_b[MAN_W-1:0]), EXP_W);
    assign w_a_zero = is_zero(FP_EXP_MAX'(i_a[W-2 -: EXP_W]), FP_MAN_MAX'(i_a[MAN_W-1:0]));
    assign w_b_zero = is_zero(FP_EXP_MAX'(i_b[W-2 -: EXP_W]), FP_MAN_MAX'(i_b[MAN_W-1:0]));

    // Sign-magnitude ordering; a negative pair reverses the magnitude comparison.
    always_comb begin
        a_gt_b    = 1'b0;
        a_eq_b    = 1'b0;
        unordered = w_a_nan || w_b_nan;
        if (unordered) begin
            a_gt_b = 1'b0;
            a_eq_b = 1'b0;
        end else if (w_a_zero && w_b_zero) begin
            a_eq_b = 1'b1;
        end else if (w_a_sign != w_b_sign) begin
            a_gt_b = !w_a_sign;
        end else if (!w_a_sign) begin
            a_gt_b = (w_a_mag > w_b_mag);
            a_eq_b = (w_a_mag == w_b_mag);
        end else begin
            a_gt_b = (w_a_mag < w_b_mag);
            a_eq_b = (w_a_mag == w_b_mag);
        end
    end

endmodule

// File: rtl/ieee754_argmax_stream.sv
// Frame-level IEEE-754 max/min tracker: accumulates the extremum and its index over
// a last-terminated stream and presents it as a registered valid/ready result.
module ieee754_argmax_stream
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int MAX_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ieee754_argmax_stream_if.slave  bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_ACC  = ST_ACC;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic             r_mode;
    logic [W-1:0]     r_value;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] r_cnt;
    logic             r_have;
    logic             r_all_nan;
    logic             r_overflow;
    logic             r_out_valid;

    logic             w_xfer_in;
    logic             w_first;
    logic             w_mode;
    logic             w_in_nan;
    logic             w_gt;
    logic             w_eq;
    logic             w_unord;
    logic             w_better;
    logic             w_load;
    logic             w_have_nx;
    logic             w_cnt_sat;

    assign bus.in_ready     = (r_state != S_DONE);
    assign bus.out_value    = r_value;
    assign bus.out_index    = r_index;
    assign bus.out_all_nan  = r_all_nan;
    assign bus.out_overflow = r_overflow;
    assign bus.out_valid    = r_out_valid;

    assign w_xfer_in = bus.in_valid && (r_state != S_DONE);
    assign w_first   = (r_state == S_IDLE);
    assign w_mode    = w_first ? bus.mode : r_mode;
    assign w_cnt_sat = (r_cnt == IDX_W'(MAX_LEN - 1));
    assign w_in_nan  = is_nan(FP_EXP_MAX'(bus.in_data[W-2 -: EXP_W]),
                              FP_MAN_MAX'(bus.in_data[MAN_W-1:0]), EXP_W);

    ieee754_cmp_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_cmp (
        .i_a       (bus.in_data),
        .i_b       (r_value),
        .a_gt_b    (w_gt),
        .a_eq_b    (w_eq),
        .unordered (w_unord)
    );

    // Strict improvement only, so ties keep the earliest index.
    always_comb begin
        w_better = 1'b0;
        if (w_mode == MODE_MAX) begin
            w_better = w_gt;
        end else begin
            w_better = !w_gt && !w_eq && !w_unord;
        end
    end

    // The first element always loads so an all-NaN frame reports its first word.
    assign w_load    = w_first || (!w_in_nan && (!r_have || w_better));
    assign w_have_nx = w_first ? !w_in_nan : (r_have || !w_in_nan);

    // Next-state decode of the frame FSM.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_ACC: begin
                if (w_xfer_in) begin
                    w_state_nx = bus.in_last ? S_DONE : S_ACC;
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Frame accumulator, element counter and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= MODE_MAX;
            r_value     <= {W{1'b0}};
            r_index     <= {IDX_W{1'b0}};
            r_cnt       <= {IDX_W{1'b0}};
            r_have      <= 1'b0;
            r_all_nan   <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_out_valid <= (w_state_nx == S_DONE);
            if (w_xfer_in) begin
                if (w_load) begin
                    r_value <= bus.in_data;
                    r_index <= r_cnt;
                end
                if (w_first) begin
                    r_mode <= bus.mode;
                end
                r_have     <= w_have_nx;
                // Overflow marks a frame that runs past MAX_LEN elements; counter pins at the top.
                r_overflow <= (w_first ? 1'b0 : r_overflow) || (w_cnt_sat && !bus.in_last);
                if (bus.in_last) begin
                    r_cnt     <= {IDX_W{1'b0}};
                    r_all_nan <= !w_have_nx;
                end else begin
                    r_cnt     <= w_cnt_sat ? r_cnt : (r_cnt + IDX_W'(1));
                    r_all_nan <= w_first ? 1'b0 : r_all_nan;
                end
            end
        end
    end

endmodule

// File: tb/tb_ieee754_argmax_stream.sv
// Directed bench for the streaming IEEE-754 extremum unit (binary32, MAX_LEN = 4).
module tb_ieee754_argmax_stream;
    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    ieee754_argmax_stream_if #(.EXP_W(8), .MAN_W(23), .MAX_LEN(4)) bus ();

    ieee754_argmax_stream #(.EXP_W(8), .MAN_W(23), .MAX_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one element; returns #1 after the edge that transferred it.
    task automatic push(input logic [31:0] d, input logic last, input logic m);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.mode     = m;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready_timeout", 32'(n < 20), 32'd1);
        if (last) chk("valid_before_last_edge", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] v, input logic [1:0] idx,
                                input logic an, input logic ov);
        chk({tag, "_valid"},   32'(bus.out_valid),    32'd1);
        chk({tag, "_value"},   bus.out_value,         v);
        chk({tag, "_index"},   32'(bus.out_index),    32'(idx));
        chk({tag, "_all_nan"}, 32'(bus.out_all_nan),  32'(an));
        chk({tag, "_ovf"},     32'(bus.out_overflow), 32'(ov));
        chk({tag, "_in_rdy"},  32'(bus.in_ready),     32'd0);
    endtask

    task automatic handoff(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_rdy_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.mode = 1'b0;
        bus.in_data = 32'h0000_0000;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),     32'd1);
        chk("rst_out_valid", 32'(bus.out_valid),    32'd0);
        chk("rst_value",     bus.out_value,         32'h0000_0000);
        chk("rst_index",     32'(bus.out_index),    32'd0);
        chk("rst_all_nan",   32'(bus.out_all_nan),  32'd0);
        chk("rst_ovf",       32'(bus.out_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Max of {3.0, 3.125, -1.0}
        push(32'h4040_0000, 1'b0, 1'b0);
        push(32'h4048_0000, 1'b0, 1'b0);
        push(32'hBF80_0000, 1'b1, 1'b0);
        check_result("max3", 32'h4048_0000, 2'd1, 1'b0, 1'b0);
        handoff("max3");

        // Min of {-3.0, -3.125, +0}; mode toggles mid-frame must be ignored
        push(32'hC040_0000, 1'b0, 1'b1);
        push(32'hC048_0000, 1'b0, 1'b0);
        push(32'h0000_0000, 1'b1, 1'b0);
        check_result("min3", 32'hC048_0000, 2'd1, 1'b0, 1'b0);
        handoff("min3");

        // Signed zeros tie: earliest index wins
        push(32'h8000_0000, 1'b0, 1'b0);
        push(32'h0000_0000, 1'b0, 1'b0);
        push(32'h8000_0000, 1'b1, 1'b0);
        check_result("zeros", 32'h8000_0000, 2'd0, 1'b0, 1'b0);
        handoff("zeros");

        // Exactly MAX_LEN elements: no overflow
        push(32'h3F80_0000, 1'b0, 1'b0);
        push(32'h4000_0000, 1'b0, 1'b0);
        push(32'h4040_0000, 1'b0, 1'b0);
        push(32'h4080_0000, 1'b1, 1'b0);
        check_result("len4", 32'h4080_0000, 2'd3, 1'b0, 1'b0);
        handoff("len4");

        // Six elements 1.0..6.0: overflow, index saturates at 3, result held under backpressure
        push(32'h3F80_0000, 1'b0, 1'b0);
        push(32'h4000_0000, 1'b0, 1'b0);
        push(32'h4040_0000, 1'b0, 1'b0);
        push(32'h4080_0000, 1'b0, 1'b0);
        push(32'h40A0_0000, 1'b0, 1'b0);
        push(32'h40C0_0000, 1'b1, 1'b0);
        check_result("ovf6", 32'h40C0_0000, 2'd3, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h7F7F_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ovf6_hold_in_rdy", 32'(bus.in_ready),     32'd0);
            chk("ovf6_hold_valid",  32'(bus.out_valid),    32'd1);
            chk("ovf6_hold_value",  bus.out_value,         32'h40C0_0000);
            chk("ovf6_hold_index",  32'(bus.out_index),    32'd3);
            chk("ovf6_hold_ovf",    32'(bus.out_overflow), 32'd1);
        end
        bus.in_valid = 1'b0;
        handoff("ovf6");

        // NaNs skipped; overflow cleared from the previous frame
        push(32'h7FC0_0000, 1'b0, 1'b0);
        push(32'h3F80_0000, 1'b0, 1'b0);
        push(32'h7FC0_0000, 1'b1, 1'b0);
        check_result("nan_mix", 32'h3F80_0000, 2'd1, 1'b0, 1'b0);
        handoff("nan_mix");

        // All-NaN frame reports the first word
        push(32'h7FC0_0000, 1'b0, 1'b0);
        push(32'hFFC0_0001, 1'b1, 1'b0);
        check_result("all_nan", 32'h7FC0_0000, 2'd0, 1'b1, 1'b0);
        handoff("all_nan");

        // Mid-frame reset discards the frame
        push(32'h3F80_0000, 1'b0, 1'b0);
        push(32'h4000_0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid",  32'(bus.out_valid),  32'd0);
        chk("midrst_in_rdy", 32'(bus.in_ready),   32'd1);
        chk("midrst_value",  bus.out_value,       32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_result", 32'(bus.out_valid), 32'd0);
        end

        // Single-element frame of -inf
        push(32'hFF80_0000, 1'b1, 1'b0);
        check_result("single", 32'hFF80_0000, 2'd0, 1'b0, 1'b0);
        handoff("single");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
